uart_rx_core: RTL and testbench

- Serial receive engine for the Schoko UART: deserialises 8N1 frames arriving on the client Tx line (PMOD_B4) into bytes.
- Presents each byte with an active-low read-acknowledge handshake, plus framing-error and overrun status.
- Sits below UART_Component's Rx buffer (address 1) and beside the transmit path; it is the receiving end of the line the transmit path drives.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_rx_core.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths.
//   rx_state_t  : receive FSM state encoding
//   DATA_BITS   : payload bits per frame (8N1)
//   rx_is_busy  : true while a frame is being received or a break is pending
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [7:0] {
        RxArm   = 8'd0,
        RxIdle  = 8'd1,
        RxStart = 8'd2,
        RxData  = 8'd3,
        RxStop  = 8'd4,
        RxBreak = 8'd5
    } rx_state_t;

    function automatic logic rx_is_busy(input rx_state_t s);
        return !((s == RxArm) || (s == RxIdle));
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus falling-edge
// detect on the synchronised value.
//   clock_i : system clock
//   rst_ni  : asynchronous active-low reset
//   rx_i    : raw serial input, idle high
//   rxs_o   : synchronised line value
//   fall_o  : high for one cycle when rxs_o goes from 1 to 0
module uart_rx_sync (
    input  logic clock_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rxs_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // All flops reset to the idle line level so leaving reset never looks
    // like a falling edge.
    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rxs_o  = sync2_q;
    assign fall_o = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 serial receive engine. Deserialises frames from rx_in into bytes and
// presents them with an active-low read-acknowledge handshake.
//   clock     : system clock
//   reset     : asynchronous active-low reset
//   rx_in     : asynchronous serial input, idle high
//   rd        : active-low read-acknowledge strobe, clears the status flags
//   out_data  : last received byte
//   rx_avail  : byte waiting to be read
//   frame_err : stop bit of the byte in out_data was sampled low
//   overrun   : a byte arrived while rx_avail was already set
//   busy      : frame or break in progress
//   irq       : rx_avail | frame_err | overrun
//
// state   | meaning
// RxArm   | wait for one full bit time of continuous idle before listening
// RxIdle  | line idle, waiting for a falling edge
// RxStart | checking the start bit at its midpoint
// RxData  | sampling the eight data bits, LSB first
// RxStop  | sampling the stop bit, then hand the byte over
// RxBreak | stop bit was low; wait for the line to return high
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 48000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rd,
    output logic [7:0] out_data,
    output logic       rx_avail,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output logic       irq
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 8) begin : g_bad_rate
            $error("uart_rx_core: CLOCK_FREQ/BAUD_RATE must be at least 8");
        end
    endgenerate

    logic                 rxs;
    logic                 fall;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 load_q, load_d;
    logic                 stop_q, stop_d;
    logic [7:0]           data_q;
    logic                 avail_q;
    logic                 ferr_q;
    logic                 ovr_q;

    uart_rx_sync u_sync (
        .clock_i (clock),
        .rst_ni  (reset),
        .rx_i    (rx_in),
        .rxs_o   (rxs),
        .fall_o  (fall)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RxArm;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            load_q  <= 1'b0;
            stop_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            load_q  <= load_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        load_d  = 1'b0;
        stop_d  = stop_q;
        case (state_q)
            RxArm: begin
                // Any low restarts the idle qualification so a reset released
                // mid-frame cannot mistake a data bit for a start bit.
                if (!rxs) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_BIT_END) begin
                    cnt_d   = '0;
                    state_d = RxIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RxIdle: begin
                cnt_d = '0;
                if (fall) state_d = RxStart;
            end
            RxStart: begin
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? RxIdle : RxData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RxData: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rxs;
                    if (bit_q == LAST_BIT) state_d = RxStop;
                    else                   bit_d   = bit_q + BIT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RxStop: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d   = '0;
                    load_d  = 1'b1;
                    stop_d  = rxs;
                    state_d = rxs ? RxIdle : RxBreak;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RxBreak: begin
                cnt_d = '0;
                if (rxs) state_d = RxIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = RxArm;
            end
        endcase
    end

    always_comb begin
        busy = rx_is_busy(state_q);
        irq  = avail_q | ferr_q | ovr_q;
    end

    // A byte load takes priority over a simultaneous read acknowledge, so the
    // new byte is never lost; the read only suppresses the overrun flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            avail_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (load_q) begin
            data_q  <= shift_q;
            avail_q <= 1'b1;
            ferr_q  <= ~stop_q;
            ovr_q   <= avail_q & rd;
        end else if (!rd) begin
            avail_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign out_data  = data_q;
    assign rx_avail  = avail_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    localparam int CLKS = 416;
    localparam int LAT  = 3955;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       rd = 1'b1;
    logic [7:0] out_data;
    logic       rx_avail;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic       irq;

    int   n_vec = 0;
    int   n_err = 0;
    int   lat_cycles = LAT + 1;
    exp_t sb_q[$];

    uart_rx_core #(.CLOCK_FREQ(48000000), .BAUD_RATE(115200)) dut (
        .clock     (clk),
        .reset     (rst_n),
        .rx_in     (rx_in),
        .rd        (rd),
        .out_data  (out_data),
        .rx_avail  (rx_avail),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy),
        .irq       (irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the line at the stop-bit level when done.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        @(posedge clk);
        #1;
        rx_in = 1'b0;
        wait_clks(CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            wait_clks(CLKS);
        end
        rx_in = stop_bit;
        wait_clks(CLKS);
    endtask

    task automatic rd_pulse();
        @(posedge clk);
        #1;
        rd = 1'b0;
        @(posedge clk);
        #1;
        rd = 1'b1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic fe, input logic ov);
        exp_t e;
        e.d  = d;
        e.fe = fe;
        e.ov = ov;
        sb_q.push_back(e);
    endtask

    // Monitor: a byte load shows up as rx_avail rising or out_data changing
    // while rx_avail is set.
    initial begin
        logic       prev_avail;
        logic [7:0] prev_data;
        exp_t       e;
        prev_avail = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && rx_avail && (!prev_avail || out_data != prev_data)) begin
                chk("sb_expected_byte", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("sb_data", 32'(out_data), 32'(e.d));
                    chk("sb_frame_err", 32'(frame_err), 32'(e.fe));
                    chk("sb_overrun", 32'(overrun), 32'(e.ov));
                    chk("sb_irq", 32'(irq), 32'd1);
                end
            end
            prev_avail = rx_avail;
            prev_data  = out_data;
        end
    end

    initial begin
        #(100000 * 20);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        wait_clks(5);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_rx_avail", 32'(rx_avail), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        wait_clks(500);

        // 1: basic byte plus latency
        push_exp(8'h4F, 1'b0, 1'b0);
        fork
            send_frame(8'h4F, 1'b1);
            begin
                int n;
                @(posedge clk);
                #1;
                n = 0;
                while (!rx_avail && n < 5000) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                lat_cycles = n;
            end
        join
        chk("t1_latency_in_window", 32'(lat_cycles >= LAT - 2 && lat_cycles <= LAT + 2), 32'd1);
        chk("t1_rx_avail", 32'(rx_avail), 32'd1);
        chk("t1_out_data", 32'(out_data), 32'h4F);
        chk("t1_frame_err", 32'(frame_err), 32'd0);
        chk("t1_overrun", 32'(overrun), 32'd0);
        chk("t1_irq", 32'(irq), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        rd_pulse();
        chk("t1_rd_avail", 32'(rx_avail), 32'd0);
        chk("t1_rd_irq", 32'(irq), 32'd0);

        // 2: false start
        rx_in = 1'b0;
        wait_clks(50);
        chk("t2_busy_during_glitch", 32'(busy), 32'd1);
        wait_clks(50);
        rx_in = 1'b1;
        wait_clks(300);
        chk("t2_busy_after", 32'(busy), 32'd0);
        chk("t2_no_avail", 32'(rx_avail), 32'd0);
        push_exp(8'h41, 1'b0, 1'b0);
        send_frame(8'h41, 1'b1);
        chk("t2_out_data", 32'(out_data), 32'h41);
        rd_pulse();

        // 3: framing error and break
        push_exp(8'h55, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0);
        chk("t3_out_data", 32'(out_data), 32'h55);
        chk("t3_frame_err", 32'(frame_err), 32'd1);
        chk("t3_busy_in_break", 32'(busy), 32'd1);
        rd_pulse();
        chk("t3_rd_frame_err", 32'(frame_err), 32'd0);
        wait_clks(830);
        chk("t3_no_second_byte", 32'(rx_avail), 32'd0);
        chk("t3_still_break", 32'(busy), 32'd1);
        rx_in = 1'b1;
        wait_clks(20);
        chk("t3_break_released", 32'(busy), 32'd0);
        push_exp(8'h41, 1'b0, 1'b0);
        send_frame(8'h41, 1'b1);
        chk("t3_next_data", 32'(out_data), 32'h41);
        chk("t3_next_frame_err", 32'(frame_err), 32'd0);
        rd_pulse();

        // 4: overrun
        push_exp(8'h31, 1'b0, 1'b0);
        send_frame(8'h31, 1'b1);
        push_exp(8'h32, 1'b0, 1'b1);
        send_frame(8'h32, 1'b1);
        chk("t4_out_data", 32'(out_data), 32'h32);
        chk("t4_overrun", 32'(overrun), 32'd1);
        rd_pulse();
        chk("t4_rd_avail", 32'(rx_avail), 32'd0);
        chk("t4_rd_overrun", 32'(overrun), 32'd0);
        chk("t4_rd_frame_err", 32'(frame_err), 32'd0);

        // 5: read acknowledge on the load cycle
        push_exp(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1);
        chk("t5_pre_avail", 32'(rx_avail), 32'd1);
        push_exp(8'hA5, 1'b0, 1'b0);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(posedge clk);
                repeat (lat_cycles - 1) @(posedge clk);
                #1;
                rd = 1'b0;
                @(posedge clk);
                #1;
                rd = 1'b1;
            end
        join
        chk("t5_rx_avail", 32'(rx_avail), 32'd1);
        chk("t5_out_data", 32'(out_data), 32'hA5);
        chk("t5_overrun", 32'(overrun), 32'd0);
        rd_pulse();

        // 6: reset mid-frame
        @(posedge clk);
        #1;
        rx_in = 1'b0;
        wait_clks(4 * CLKS);
        rst_n = 1'b0;
        wait_clks(3);
        chk("t6_rst_out_data", 32'(out_data), 32'h00);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_clks(1000);
        chk("t6_no_byte", 32'(rx_avail), 32'd0);
        chk("t6_armed_not_busy", 32'(busy), 32'd0);
        rx_in = 1'b1;
        wait_clks(500);
        push_exp(8'h7E, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b1);
        chk("t6_out_data", 32'(out_data), 32'h7E);
        chk("t6_frame_err", 32'(frame_err), 32'd0);
        chk("t6_overrun", 32'(overrun), 32'd0);

        wait_clks(10);
        chk("sb_all_consumed", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
